// File: rtl/fifo_rd_drainer_if.sv
// Bundle of FIFO read-port, stream and control/status signals for fifo_rd_drainer.
// master = drainer side, slave = FIFO/consumer/controller side.
interface fifo_rd_drainer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4
);
  logic              en;
  logic              flush;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  counter;
  logic [DATA_W-1:0] data_out;
  logic              r_en;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic              busy;
  logic              ovf_seen;

  modport master (
    input  en, flush, empty, full, counter, data_out, m_ready,
    output r_en, m_valid, m_data, busy, ovf_seen
  );

  modport slave (
    output en, flush, empty, full, counter, data_out, m_ready,
    input  r_en, m_valid, m_data, busy, ovf_seen
  );
endinterface

// File: rtl/fifo_rd_drainer.sv
// Read-side master for a synchronous FIFO: issues r_en, buffers data_out in a
// 2-entry skid buffer and presents it as a valid/ready stream. Optional macro RD_WATERMARK_EN.
module fifo_rd_drainer #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned WM_LEVEL = 4
) (
  input  logic             clk,
  input  logic             reset,
  fifo_rd_drainer_if.master bus
);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t            r_state;
  logic [1:0]        r_occ;
  logic              r_rd_pend;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [DATA_W-1:0] r_buf [2];
  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic              r_ovf;

  logic              w_pop;
  logic              w_push;
  logic              w_r_en;
  logic              w_start;
  logic [2:0]        w_inflight;
  logic [1:0]        w_occ_nxt;
  logic              w_rd_ptr_nxt;
  logic [DATA_W-1:0] w_head_nxt;

  assign w_pop  = r_m_valid && bus.m_ready;
  assign w_push = r_rd_pend;

  // Words held after this cycle's pop; a new read may only fill a free slot.
  assign w_inflight = 3'(r_occ) + 3'(r_rd_pend) - 3'(w_pop);
  assign w_r_en     = (r_state == S_DRAIN) && bus.en && !bus.empty &&
                      (bus.counter != '0) && (w_inflight < 3'd2);

`ifdef RD_WATERMARK_EN
  assign w_start = bus.en && !bus.empty &&
                   ((bus.counter >= CNT_W'(WM_LEVEL)) || bus.flush);
`else
  logic w_unused;
  assign w_start  = bus.en && !bus.empty;
  assign w_unused = bus.flush ^ WM_LEVEL[0];
`endif

  assign w_occ_nxt    = r_occ + 2'(w_push) - 2'(w_pop);
  assign w_rd_ptr_nxt = r_rd_ptr ^ w_pop;
  // Buffer drains to empty while a word lands: the new head bypasses the array.
  assign w_head_nxt   = (w_push && (r_wr_ptr == w_rd_ptr_nxt)) ? bus.data_out
                                                               : r_buf[w_rd_ptr_nxt];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_occ     <= '0;
      r_rd_pend <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_buf[0]  <= '0;
      r_buf[1]  <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE:  if (w_start) r_state <= S_DRAIN;
        S_DRAIN: if ((bus.empty && !r_rd_pend && !w_r_en) || (!bus.en && !r_rd_pend))
                   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      r_rd_pend <= w_r_en;
      if (w_push) begin
        r_buf[r_wr_ptr] <= bus.data_out;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_occ     <= w_occ_nxt;
      r_m_valid <= (w_occ_nxt != 2'd0);
      if (w_occ_nxt != 2'd0) r_m_data <= w_head_nxt;
      r_ovf     <= r_ovf | bus.full;
    end
  end

  assign bus.r_en     = w_r_en;
  assign bus.m_valid  = r_m_valid;
  assign bus.m_data   = r_m_data;
  assign bus.busy     = (r_state == S_DRAIN) || r_rd_pend || (r_occ != 2'd0);
  assign bus.ovf_seen = r_ovf;

endmodule

// File: tb/tb_fifo_rd_drainer.sv
// Directed bench for fifo_rd_drainer with a behavioural 8-deep FIFO on the read port.
module tb_fifo_rd_drainer;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fifo_rd_drainer_if #(.DATA_W(8), .CNT_W(4)) bus ();

  fifo_rd_drainer #(.DATA_W(8), .CNT_W(4), .WM_LEVEL(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural FIFO: data_out registered one cycle after a sampled r_en.
  logic [7:0] f_mem [8];
  logic [2:0] f_wp = '0;
  logic [2:0] f_rp = '0;
  logic [3:0] f_cnt = '0;
  logic [7:0] f_dout = '0;
  logic       f_wr = 1'b0;
  logic       f_clr = 1'b0;
  logic [7:0] f_wdata = '0;
  logic       f_rd, f_wok;

  assign f_rd  = bus.r_en && (f_cnt != 4'd0);
  assign f_wok = f_wr && (f_cnt != 4'd8);

  always @(posedge clk) begin
    if (f_clr) begin
      f_wp  <= '0;
      f_rp  <= '0;
      f_cnt <= '0;
    end else begin
      if (f_rd) begin
        f_dout <= f_mem[f_rp];
        f_rp   <= f_rp + 3'd1;
      end
      if (f_wok) begin
        f_mem[f_wp] <= f_wdata;
        f_wp        <= f_wp + 3'd1;
      end
      f_cnt <= f_cnt + 4'(f_wok) - 4'(f_rd);
    end
  end

  assign bus.empty    = (f_cnt == 4'd0);
  assign bus.full     = (f_cnt == 4'd8);
  assign bus.counter  = f_cnt;
  assign bus.data_out = f_dout;

  // Monitor: read/transfer log, underflow, occupancy bound and hold checks.
  int         cyc = 0;
  int         n_ren = 0, first_ren = 0, last_ren = 0, first_vld = 0, last_vld = 0;
  int         tot_rd = 0, tot_rx = 0;
  logic [7:0] rx [$];
  logic       p_v = 1'b0, p_r = 1'b0;
  logic [7:0] p_d = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      tot_rd = 0;
      tot_rx = 0;
      p_v    = 1'b0;
      p_r    = 1'b0;
    end else begin
      if (bus.r_en) begin
        n_checks++;
        if (bus.empty || bus.counter == 4'd0) begin
          n_errors++;
          $display("FAIL underflow: r_en=1 with empty=%0b counter=%0d, required no read", bus.empty, bus.counter);
        end
        if (n_ren == 0) first_ren = cyc;
        last_ren = cyc;
        n_ren++;
        tot_rd++;
      end
      if (p_v && !p_r) begin
        n_checks++;
        if (!bus.m_valid || bus.m_data !== p_d) begin
          n_errors++;
          $display("FAIL hold: m_valid=%0b m_data=%02h, required 1/%02h", bus.m_valid, bus.m_data, p_d);
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        if (rx.size() == 0) first_vld = cyc;
        last_vld = cyc;
        rx.push_back(bus.m_data);
        tot_rx++;
      end
      n_checks++;
      if (tot_rd - tot_rx > 2) begin
        n_errors++;
        $display("FAIL occupancy: %0d words buffered+in flight, required <= 2", tot_rd - tot_rx);
      end
      p_v = bus.m_valid;
      p_r = bus.m_ready;
      p_d = bus.m_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    f_wr    = 1'b1;
    f_wdata = d;
    step();
    f_wr    = 1'b0;
  endtask

  task automatic fifo_clear();
    f_clr = 1'b1;
    step();
    f_clr = 1'b0;
  endtask

  task automatic mon_clear();
    n_ren = 0;
    rx.delete();
  endtask

  task automatic start_drain();
    bus.en    = 1'b1;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int k = 0;
    while (k < max && (bus.busy || !bus.empty)) begin
      step();
      k++;
    end
    n_checks++;
    if (bus.busy || !bus.empty) begin
      n_errors++;
      $display("FAIL %s idle timeout: busy=%0b empty=%0b, required busy=0 empty=1", tag, bus.busy, bus.empty);
    end
  endtask

  task automatic check_rx(input int n, input logic [7:0] base, input logic [7:0] inc, input string tag);
    logic [7:0] e;
    n_checks++;
    if (rx.size() != n) begin
      n_errors++;
      $display("FAIL %s count: got %0d words, required %0d", tag, rx.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      e = base + 8'(i) * inc;
      if (i < rx.size()) begin
        n_checks++;
        if (rx[i] !== e) begin
          n_errors++;
          $display("FAIL %s word%0d: got %02h, required %02h", tag, i, rx[i], e);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.en = 1'b1; bus.m_ready = 1'b1; bus.flush = 1'b0;
    step();
    push(8'h11);
    push(8'h22);
    @(negedge clk);
    n_checks += 5;
    if (bus.r_en !== 1'b0)     begin n_errors++; $display("FAIL rst_r_en: got %0b, required 0", bus.r_en); end
    if (bus.m_valid !== 1'b0)  begin n_errors++; $display("FAIL rst_m_valid: got %0b, required 0", bus.m_valid); end
    if (bus.m_data !== 8'h00)  begin n_errors++; $display("FAIL rst_m_data: got %02h, required 00", bus.m_data); end
    if (bus.busy !== 1'b0)     begin n_errors++; $display("FAIL rst_busy: got %0b, required 0", bus.busy); end
    if (bus.ovf_seen !== 1'b0) begin n_errors++; $display("FAIL rst_ovf: got %0b, required 0", bus.ovf_seen); end
    step();
    bus.en = 1'b0;
    reset  = 1'b1;
    fifo_clear();
    step();
  endtask

  task automatic test_streaming();
    bus.en = 1'b0; bus.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'((i + 1) * 17));
    mon_clear();
    bus.en = 1'b1;
    wait_idle(60, "stream");
    n_checks += 4;
    if (n_ren != 8) begin n_errors++; $display("FAIL stream_reads: got %0d, required 8", n_ren); end
    if (last_ren - first_ren != 7) begin n_errors++; $display("FAIL stream_ren_span: got %0d, required 7", last_ren - first_ren); end
    if (first_vld - first_ren != 2) begin n_errors++; $display("FAIL stream_latency: got %0d, required 2", first_vld - first_ren); end
    if (last_vld - first_vld != 7) begin n_errors++; $display("FAIL stream_vld_span: got %0d, required 7", last_vld - first_vld); end
    check_rx(8, 8'h11, 8'h11, "stream");
    bus.en = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    bus.en = 1'b0; bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'((i + 1) * 17));
    mon_clear();
    bus.en = 1'b1;
    repeat (10) step();
    @(negedge clk);
    n_checks += 3;
    if (n_ren != 2) begin n_errors++; $display("FAIL bp_reads: got %0d, required 2", n_ren); end
    if (bus.m_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid: got %0b, required 1", bus.m_valid); end
    if (bus.m_data !== 8'h11) begin n_errors++; $display("FAIL bp_data: got %02h, required 11", bus.m_data); end
    step();
    bus.m_ready = 1'b1;
    wait_idle(40, "bp");
    n_checks++;
    if (n_ren != 5) begin n_errors++; $display("FAIL bp_total_reads: got %0d, required 5", n_ren); end
    check_rx(5, 8'h11, 8'h11, "bp");
    bus.en = 1'b0;
    step();
  endtask

  task automatic test_single_word();
    int k = 0;
    bus.en = 1'b0; bus.m_ready = 1'b1;
    push(8'hA5);
    mon_clear();
    start_drain();
    while (rx.size() == 0 && k < 20) begin
      step();
      k++;
    end
    step();
    @(negedge clk);
    n_checks += 2;
    if (bus.busy !== 1'b0)    begin n_errors++; $display("FAIL single_busy: got %0b, required 0", bus.busy); end
    if (bus.m_valid !== 1'b0) begin n_errors++; $display("FAIL single_valid: got %0b, required 0", bus.m_valid); end
    repeat (5) step();
    n_checks++;
    if (n_ren != 1) begin n_errors++; $display("FAIL single_reads: got %0d, required 1", n_ren); end
    check_rx(1, 8'hA5, 8'h00, "single");
    bus.en = 1'b0;
    step();
  endtask

  task automatic test_abort();
    int k = 0;
    bus.en = 1'b0; bus.m_ready = 1'b1;
    push(8'h31); push(8'h32); push(8'h33);
    mon_clear();
    start_drain();
    while (n_ren == 0 && k < 20) begin
      step();
      k++;
    end
    bus.en = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (bus.r_en !== 1'b0) begin n_errors++; $display("FAIL abort_r_en: got %0b, required 0", bus.r_en); end
    if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL abort_busy: got %0b, required 1", bus.busy); end
    repeat (5) step();
    n_checks++;
    if (n_ren != 1) begin n_errors++; $display("FAIL abort_reads: got %0d, required 1", n_ren); end
    check_rx(1, 8'h31, 8'h00, "abort");
    // Restart with the consumer stalled, then reset while words are buffered.
    bus.m_ready = 1'b0;
    start_drain();
    repeat (4) step();
    n_checks += 2;
    if (bus.m_valid !== 1'b1) begin n_errors++; $display("FAIL pre_rst_valid: got %0b, required 1", bus.m_valid); end
    if (bus.busy !== 1'b1)    begin n_errors++; $display("FAIL pre_rst_busy: got %0b, required 1", bus.busy); end
    #1 reset = 1'b0;
    #1;
    n_checks += 4;
    if (bus.m_valid !== 1'b0) begin n_errors++; $display("FAIL arst_valid: got %0b, required 0", bus.m_valid); end
    if (bus.busy !== 1'b0)    begin n_errors++; $display("FAIL arst_busy: got %0b, required 0", bus.busy); end
    if (bus.r_en !== 1'b0)    begin n_errors++; $display("FAIL arst_r_en: got %0b, required 0", bus.r_en); end
    if (bus.m_data !== 8'h00) begin n_errors++; $display("FAIL arst_data: got %02h, required 00", bus.m_data); end
    step();
    bus.en = 1'b0; bus.m_ready = 1'b1;
    reset = 1'b1;
    fifo_clear();
    repeat (3) step();
    n_checks++;
    if (rx.size() != 1) begin n_errors++; $display("FAIL arst_discard: got %0d words, required 1", rx.size()); end
  endtask

  task automatic test_overflow();
    bus.en = 1'b0; bus.m_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.ovf_seen !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: got %0b, required 0", bus.ovf_seen); end
    step();
    for (int i = 0; i < 8; i++) push(8'(8'h61 + i));
    step();
    @(negedge clk);
    n_checks++;
    if (bus.ovf_seen !== 1'b1) begin n_errors++; $display("FAIL ovf_set: got %0b, required 1", bus.ovf_seen); end
    step();
    mon_clear();
    start_drain();
    wait_idle(60, "ovf");
    n_checks += 2;
    if (bus.ovf_seen !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %0b, required 1", bus.ovf_seen); end
    if (n_ren != 8) begin n_errors++; $display("FAIL ovf_reads: got %0d, required 8", n_ren); end
    check_rx(8, 8'h61, 8'h01, "ovf");
    bus.en = 1'b0;
    step();
  endtask

`ifdef RD_WATERMARK_EN
  task automatic test_watermark();
    bus.en = 1'b1; bus.m_ready = 1'b1;
    mon_clear();
    push(8'h41); push(8'h42); push(8'h43);
    repeat (10) step();
    @(negedge clk);
    n_checks += 2;
    if (n_ren != 0) begin n_errors++; $display("FAIL wm_below: got %0d reads, required 0", n_ren); end
    if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL wm_busy: got %0b, required 0", bus.busy); end
    step();
    push(8'h44);
    wait_idle(40, "wm");
    n_checks++;
    if (n_ren != 4) begin n_errors++; $display("FAIL wm_reads: got %0d, required 4", n_ren); end
    check_rx(4, 8'h41, 8'h01, "wm");
    mon_clear();
    push(8'h51); push(8'h52);
    repeat (5) step();
    @(negedge clk);
    n_checks++;
    if (n_ren != 0) begin n_errors++; $display("FAIL wm_preflush: got %0d reads, required 0", n_ren); end
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    wait_idle(40, "flush");
    n_checks++;
    if (n_ren != 2) begin n_errors++; $display("FAIL flush_reads: got %0d, required 2", n_ren); end
    check_rx(2, 8'h51, 8'h01, "flush");
    bus.en = 1'b0;
    step();
  endtask
`endif

  initial begin
    bus.en = 1'b0; bus.flush = 1'b0; bus.m_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_single_word();
    test_abort();
    test_overflow();
`ifdef RD_WATERMARK_EN
    test_watermark();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
